// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD serial-link receiver: command codes,
// decoder state encoding, pixel layout and the window-validity rule.
package lcd_pkg;

  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    DEC_IDLE     = 3'd0,
    DEC_CASET    = 3'd1,
    DEC_PASET    = 3'd2,
    DEC_RAMWR_HI = 3'd3,
    DEC_RAMWR_LO = 3'd4
  } dec_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // A column/page window is accepted only when start <= end < limit.
  function automatic logic win_ok(input logic [15:0] s, input logic [15:0] e,
                                  input int unsigned lim);
    return (s <= e) && (32'(e) < lim);
  endfunction

endpackage

// File: rtl/lcd_spi_receiver_if.sv
// The four LCD link pins; the console side drives them, the display side samples.
interface lcd_spi_receiver_if;
  logic sda;
  logic scl;
  logic cs;
  logic rs;

  modport master (output sda, output scl, output cs, output rs);
  modport slave  (input  sda, input  scl, input  cs, input  rs);
endinterface

// File: rtl/lcd_spi_deser.sv
// Pin synchronizers, scl rising-edge detect and the 8-bit shift register.
// Emits one registered byte (with its rs flag) per completed 8-bit group.
module lcd_spi_deser #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  lcd_spi_receiver_if.slave  link,
  output logic               byte_valid,
  output logic [7:0]         byte_out,
  output logic               byte_is_data
);

  localparam int unsigned PINS = 4;
  // Pin order {sda, scl, cs, rs}; idle link has cs high and scl low.
  localparam logic [PINS-1:0] PIN_IDLE = 4'b0010;

  logic [SYNC_STAGES-1:0][PINS-1:0] sync_q, sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_is_data_q, byte_is_data_d;

  logic sda_s, scl_s, cs_s, rs_s;
  logic scl_rise;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {link.sda, link.scl, link.cs, link.rs};
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign {sda_s, scl_s, cs_s, rs_s} = sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;

  // A high cs takes priority over any coincident scl edge.
  always_comb begin
    scl_prev_d     = scl_s;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    byte_valid_d   = 1'b0;
    byte_out_d     = byte_out_q;
    byte_is_data_d = byte_is_data_q;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (scl_rise) begin
      shift_d   = {shift_q[6:0], sda_s};
      bit_cnt_d = 3'(bit_cnt_q + 3'd1);
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d   = 1'b1;
        byte_out_d     = {shift_q[6:0], sda_s};
        byte_is_data_d = rs_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q         <= {SYNC_STAGES{PIN_IDLE}};
      scl_prev_q     <= 1'b0;
      shift_q        <= 8'd0;
      bit_cnt_q      <= 3'd0;
      byte_valid_q   <= 1'b0;
      byte_out_q     <= 8'd0;
      byte_is_data_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      scl_prev_q     <= scl_prev_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_out_q     <= byte_out_d;
      byte_is_data_q <= byte_is_data_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_out     = byte_out_q;
  assign byte_is_data = byte_is_data_q;

endmodule

// File: rtl/lcd_spi_receiver.sv
// Display-side LCD link receiver: deserializes the pin stream and decodes the
// controller command set into status flags, window registers and RGB565 pixels.
module lcd_spi_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  lcd_spi_receiver_if.slave          link,
  output logic                       byte_valid,
  output logic [7:0]                 byte_out,
  output logic                       byte_is_data,
  output logic                       pixel_valid,
  output logic [15:0]                pixel,
  output logic [$clog2(WIDTH)-1:0]   px,
  output logic [$clog2(HEIGHT)-1:0]  py,
  output logic                       frame_done,
  output logic                       sleep_out,
  output logic                       display_on
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  localparam logic [2:0] ST_IDLE     = 3'(DEC_IDLE);
  localparam logic [2:0] ST_CASET    = 3'(DEC_CASET);
  localparam logic [2:0] ST_PASET    = 3'(DEC_PASET);
  localparam logic [2:0] ST_RAMWR_HI = 3'(DEC_RAMWR_HI);
  localparam logic [2:0] ST_RAMWR_LO = 3'(DEC_RAMWR_LO);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_is_data;

  lcd_spi_deser #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deser (
    .clk          (clk),
    .reset        (reset),
    .link         (link),
    .byte_valid   (rx_valid),
    .byte_out     (rx_byte),
    .byte_is_data (rx_is_data)
  );

  logic [2:0]    state_q, state_d;
  logic [1:0]    pidx_q, pidx_d;
  logic [23:0]   stage_q, stage_d;
  logic [XW-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
  logic [YW-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d;
  logic [7:0]    hi_q, hi_d;
  logic          pixel_valid_q, pixel_valid_d;
  rgb565_t       pixel_q, pixel_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic          frame_done_q, frame_done_d;
  logic          sleep_out_q, sleep_out_d;
  logic          display_on_q, display_on_d;

  // The fourth parameter byte completes the end value directly from the wire.
  logic [15:0] par_start, par_end;
  assign par_start = stage_q[23:8];
  assign par_end   = {stage_q[7:0], rx_byte};

  always_comb begin
    state_d       = state_q;
    pidx_d        = pidx_q;
    stage_d       = stage_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    x_d           = x_q;
    y_d           = y_q;
    hi_d          = hi_q;
    pixel_valid_d = 1'b0;
    pixel_d       = pixel_q;
    px_d          = px_q;
    py_d          = py_q;
    frame_done_d  = 1'b0;
    sleep_out_d   = sleep_out_q;
    display_on_d  = display_on_q;

    if (rx_valid) begin
      if (!rx_is_data) begin
        state_d = ST_IDLE;
        pidx_d  = 2'd0;
        case (rx_byte)
          CMD_SLPOUT:  sleep_out_d  = 1'b1;
          CMD_DISPON:  display_on_d = 1'b1;
          CMD_DISPOFF: display_on_d = 1'b0;
          CMD_CASET:   state_d      = ST_CASET;
          CMD_PASET:   state_d      = ST_PASET;
          CMD_RAMWR: begin
            x_d     = xs_q;
            y_d     = ys_q;
            state_d = ST_RAMWR_HI;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            stage_d = {stage_q[15:0], rx_byte};
            pidx_d  = 2'(pidx_q + 2'd1);
            if (pidx_q == 2'd3) begin
              state_d = ST_IDLE;
              if (state_q == ST_CASET) begin
                if (win_ok(par_start, par_end, WIDTH)) begin
                  xs_d = XW'(par_start);
                  xe_d = XW'(par_end);
                end
              end else if (win_ok(par_start, par_end, HEIGHT)) begin
                ys_d = YW'(par_start);
                ye_d = YW'(par_end);
              end
            end
          end
          ST_RAMWR_HI: begin
            hi_d    = rx_byte;
            state_d = ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            pixel_valid_d = 1'b1;
            pixel_d       = {hi_q, rx_byte};
            px_d          = x_q;
            py_d          = y_q;
            state_d       = ST_RAMWR_HI;
            // Raster-advance inside the window, wrapping back to its origin.
            if (x_q == xe_q) begin
              x_d = xs_q;
              if (y_q == ye_q) begin
                y_d          = ys_q;
                frame_done_d = 1'b1;
              end else begin
                y_d = YW'(y_q + 1'b1);
              end
            end else begin
              x_d = XW'(x_q + 1'b1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pidx_q        <= 2'd0;
      stage_q       <= 24'd0;
      xs_q          <= '0;
      xe_q          <= XW'(WIDTH - 1);
      ys_q          <= '0;
      ye_q          <= YW'(HEIGHT - 1);
      x_q           <= '0;
      y_q           <= '0;
      hi_q          <= 8'd0;
      pixel_valid_q <= 1'b0;
      pixel_q       <= '0;
      px_q          <= '0;
      py_q          <= '0;
      frame_done_q  <= 1'b0;
      sleep_out_q   <= 1'b0;
      display_on_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pidx_q        <= pidx_d;
      stage_q       <= stage_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hi_q          <= hi_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q       <= pixel_d;
      px_q          <= px_d;
      py_q          <= py_d;
      frame_done_q  <= frame_done_d;
      sleep_out_q   <= sleep_out_d;
      display_on_q  <= display_on_d;
    end
  end

  assign byte_valid   = rx_valid;
  assign byte_out     = rx_byte;
  assign byte_is_data = rx_is_data;
  assign pixel_valid  = pixel_valid_q;
  assign pixel        = pixel_q;
  assign px           = px_q;
  assign py           = py_q;
  assign frame_done   = frame_done_q;
  assign sleep_out    = sleep_out_q;
  assign display_on   = display_on_q;

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Directed + randomized bench for lcd_spi_receiver on a reduced 16x12 panel,
// checked against a byte-level behavioural model of the controller.
module tb_lcd_spi_receiver;

  localparam int W        = 16;
  localparam int H        = 12;
  localparam int SCL_HALF = 3;

  typedef struct {
    logic [15:0] pix;
    logic [31:0] x;
    logic [31:0] y;
    logic        fd;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_spi_receiver_if link ();

  logic        byte_valid, byte_is_data, pixel_valid, frame_done, sleep_out, display_on;
  logic [7:0]  byte_out;
  logic [15:0] pixel;
  logic [3:0]  px;
  logic [3:0]  py;

  lcd_spi_receiver #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .link         (link),
    .byte_valid   (byte_valid),
    .byte_out     (byte_out),
    .byte_is_data (byte_is_data),
    .pixel_valid  (pixel_valid),
    .pixel        (pixel),
    .px           (px),
    .py           (py),
    .frame_done   (frame_done),
    .sleep_out    (sleep_out),
    .display_on   (display_on)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0] got_bytes[$];
  logic [8:0] exp_bytes[$];
  pix_t       got_pix[$];
  pix_t       exp_pix[$];
  pix_t       mon_p;

  // Model state: mode 0 idle, 1 column params, 2 page params, 3 memory write.
  int   m_mode, m_np, m_k;
  int   m_par[4];
  int   m_xs, m_xe, m_ys, m_ye;
  int   r_xs, r_xe, r_ys, r_ye;
  bit   m_have_hi, m_sleep, m_disp;
  logic [7:0] m_hi;

  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) got_bytes.push_back({byte_is_data, byte_out});
      if (pixel_valid) begin
        mon_p.pix = pixel;
        mon_p.x   = 32'(px);
        mon_p.y   = 32'(py);
        mon_p.fd  = frame_done;
        got_pix.push_back(mon_p);
      end
    end
  end

  function automatic void model_reset();
    m_mode = 0; m_np = 0; m_k = 0; m_have_hi = 0; m_hi = 8'd0;
    m_sleep = 0; m_disp = 0;
    m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
    r_xs = 0; r_xe = W - 1; r_ys = 0; r_ye = H - 1;
  endfunction

  function automatic void model_byte(input logic rs, input logic [7:0] b);
    int s, e, w, n, idx;
    pix_t p;
    exp_bytes.push_back({rs, b});
    if (!rs) begin
      m_mode = 0; m_np = 0; m_have_hi = 0;
      case (b)
        8'h11: m_sleep = 1;
        8'h29: m_disp = 1;
        8'h28: m_disp = 0;
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin
          m_mode = 3; m_k = 0;
          r_xs = m_xs; r_xe = m_xe; r_ys = m_ys; r_ye = m_ye;
        end
        default: ;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par[m_np] = int'(b);
      m_np++;
      if (m_np == 4) begin
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        if (m_mode == 1 && s <= e && e < W) begin m_xs = s; m_xe = e; end
        if (m_mode == 2 && s <= e && e < H) begin m_ys = s; m_ye = e; end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        m_have_hi = 0;
        w   = r_xe - r_xs + 1;
        n   = w * (r_ye - r_ys + 1);
        idx = m_k % n;
        p.pix = {m_hi, b};
        p.x   = 32'(r_xs + idx % w);
        p.y   = 32'(r_ys + idx / w);
        p.fd  = (idx == n - 1);
        exp_pix.push_back(p);
        m_k++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic rs_i, input logic [7:0] b);
    logic [7:0] v;
    v = b;
    link.cs = 1'b0;
    link.rs = rs_i;
    for (int i = 7; i >= 0; i--) begin
      link.sda = v[i];
      repeat (SCL_HALF) @(negedge clk);
      link.scl = 1'b1;
      repeat (SCL_HALF) @(negedge clk);
      link.scl = 1'b0;
    end
    model_byte(rs_i, b);
  endtask

  task automatic send_pixels(input int n);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom);
      send_byte(1'b1, v[15:8]);
      send_byte(1'b1, v[7:0]);
    end
  endtask

  task automatic send_window(input logic [7:0] cmd, input int s, input int e);
    logic [15:0] sv, ev;
    sv = 16'(s);
    ev = 16'(e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, sv[15:8]);
    send_byte(1'b1, sv[7:0]);
    send_byte(1'b1, ev[15:8]);
    send_byte(1'b1, ev[7:0]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    chk($sformatf("%s.nbytes", tag), 32'(got_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    chk($sformatf("%s.npix", tag), 32'(got_pix.size()), 32'(exp_pix.size()));
    for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
      chk($sformatf("%s.pix%0d", tag, i), 32'(got_pix[i].pix), 32'(exp_pix[i].pix));
      chk($sformatf("%s.px%0d", tag, i), got_pix[i].x, exp_pix[i].x);
      chk($sformatf("%s.py%0d", tag, i), got_pix[i].y, exp_pix[i].y);
      chk($sformatf("%s.fd%0d", tag, i), 32'(got_pix[i].fd), 32'(exp_pix[i].fd));
    end
    chk($sformatf("%s.sleep_out", tag), 32'(sleep_out), 32'(m_sleep));
    chk($sformatf("%s.display_on", tag), 32'(display_on), 32'(m_disp));
    got_bytes.delete(); exp_bytes.delete(); got_pix.delete(); exp_pix.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".byte_valid"},   32'(byte_valid),   32'd0);
    chk({tag, ".byte_out"},     32'(byte_out),     32'd0);
    chk({tag, ".byte_is_data"}, 32'(byte_is_data), 32'd0);
    chk({tag, ".pixel_valid"},  32'(pixel_valid),  32'd0);
    chk({tag, ".pixel"},        32'(pixel),        32'd0);
    chk({tag, ".px"},           32'(px),           32'd0);
    chk({tag, ".py"},           32'(py),           32'd0);
    chk({tag, ".frame_done"},   32'(frame_done),   32'd0);
    chk({tag, ".sleep_out"},    32'(sleep_out),    32'd0);
    chk({tag, ".display_on"},   32'(display_on),   32'd0);
  endtask

  initial begin
    int nfd;
    logic [7:0] cmds[6];
    link.sda = 1'b0; link.scl = 1'b0; link.cs = 1'b1; link.rs = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Status commands
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h29);
    settle();
    chk("status.sleep_out", 32'(sleep_out), 32'd1);
    chk("status.display_on", 32'(display_on), 32'd1);
    compare_all("status");

    // Full-frame raster scan over the whole panel
    send_byte(1'b0, 8'h2C);
    send_pixels(W * H);
    settle();
    nfd = 0;
    foreach (got_pix[i]) if (got_pix[i].fd) nfd++;
    chk("frame.npix_const", 32'(got_pix.size()), 32'(W * H));
    chk("frame.fd_count", 32'(nfd), 32'd1);
    if (got_pix.size() > 0) begin
      chk("frame.last_x", got_pix[$].x, 32'(W - 1));
      chk("frame.last_y", got_pix[$].y, 32'(H - 1));
      chk("frame.last_fd", 32'(got_pix[$].fd), 32'd1);
    end
    compare_all("frame");

    // 2x2 window with wrap
    send_window(8'h2A, 10, 11);
    send_window(8'h2B, 5, 6);
    send_byte(1'b0, 8'h2C);
    send_pixels(5);
    settle();
    compare_all("window");

    // Rejected window (start > end) after reset leaves full-panel window
    do_reset();
    send_window(8'h2A, 16'h0140, 0);
    send_byte(1'b0, 8'h2C);
    send_pixels(2);
    settle();
    if (got_pix.size() > 0) begin
      chk("badwin.x0", got_pix[0].x, 32'd0);
      chk("badwin.y0", got_pix[0].y, 32'd0);
    end
    compare_all("badwin");

    // Boundary: end == WIDTH rejected, end == WIDTH-1 accepted
    send_window(8'h2A, 3, W);
    send_byte(1'b0, 8'h2C);
    send_pixels(1);
    send_window(8'h2A, 3, W - 1);
    send_window(8'h2B, H - 1, H - 1);
    send_byte(1'b0, 8'h2C);
    send_pixels(W - 3 + 1);
    settle();
    compare_all("boundary");

    // Randomized windows and commands
    cmds[0] = 8'h11; cmds[1] = 8'h28; cmds[2] = 8'h29;
    cmds[3] = 8'h00; cmds[4] = 8'h3A; cmds[5] = 8'h2C;
    for (int it = 0; it < 8; it++) begin
      send_window(8'h2A, int'($urandom_range(0, W + 3)), int'($urandom_range(0, W + 3)));
      send_window(8'h2B, int'($urandom_range(0, H + 3)), int'($urandom_range(0, H + 3)));
      send_byte(1'b0, cmds[$urandom_range(0, 5)]);
      send_byte(1'b1, 8'($urandom));
      send_byte(1'b0, 8'h2C);
      send_pixels(int'($urandom_range(1, 6)));
      settle();
      compare_all($sformatf("rand%0d", it));
    end

    // Partial byte discarded by cs rising
    @(negedge clk);
    link.cs = 1'b0;
    for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
      link.sda = 1'($urandom);
      repeat (SCL_HALF) @(negedge clk);
      link.scl = 1'b1;
      repeat (SCL_HALF) @(negedge clk);
      link.scl = 1'b0;
    end
    repeat (SCL_HALF) @(negedge clk);
    link.cs = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(1'b0, 8'h2C);
    settle();
    chk("cs_abort.byte_out", 32'(byte_out), 32'h2C);
    compare_all("cs_abort");

    // Reset between high and low pixel bytes
    send_byte(1'b1, 8'hA5);
    settle();
    compare_all("pre_reset");
    do_reset();
    check_reset_values("midpix");
    send_byte(1'b1, 8'h5A);
    settle();
    compare_all("post_reset_lo");
    send_byte(1'b0, 8'h2C);
    send_pixels(1);
    settle();
    compare_all("post_reset");

    link.cs = 1'b1;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_spi_receiver.md
# lcd_spi_receiver

Display-side end of the LCD serial link: receives the 4-wire stream (sda, scl, cs, rs) produced by the console's LCD driver and decodes it into command bytes, parameter bytes and RGB565 pixels with screen coordinates. It models the display controller's command set (sleep-out, display-on, column/page window, memory write). It serves as the self-checking sink in link benches and as the front end of an on-FPGA framebuffer capture path.

## Interface

Parameters:

- WIDTH, 320, horizontal pixels.
- HEIGHT, 240, vertical lines.
- SYNC_STAGES, 2, synchronizer depth for sda/scl/cs/rs.

Ports:

- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- sda  in  1  serial data, MSB first, sampled on scl rising edge.
- scl  in  1  serial clock, asynchronous to clk.
- cs  in  1  frame select, active low.
- rs  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_out  out  8  received byte; held until the next byte.
- byte_is_data  out  1  rs value of byte_out.
- pixel_valid  out  1  one-cycle pulse per completed RGB565 pixel.
- pixel  out  16  {R5,G6,B5}, high byte first on the wire.
- px  out  $clog2(WIDTH)  column of pixel.
- py  out  $clog2(HEIGHT)  row of pixel.
- frame_done  out  1  pulse with the last pixel of the window.
- sleep_out  out  1  set by 0x11.
- display_on  out  1  set by 0x29, cleared by 0x28.

## Operation

- Deserializer:
  - Synchronize the four pins; detect scl rising edges.
  - While cs is low, shift sda in on each rising edge and count bits 0–7.
  - On the 8th bit, latch the byte and rs, then pulse byte_valid.
  - cs high clears the bit counter and discards any partial byte.
- Decoder FSM states: IDLE, CASET (param index 0–3), PASET (param index 0–3), RAMWR_HI, RAMWR_LO.
- Command bytes (rs=0) are accepted in any state and abort the current sequence:
  - 0x11 sets sleep_out, then IDLE.
  - 0x29 / 0x28 set / clear display_on, then IDLE.
  - 0x2A enters CASET. 0x2B enters PASET. Parameter index is cleared on entry.
  - 0x2C loads x←xs, y←ys and enters RAMWR_HI.
  - Any other command goes to IDLE.
- CASET/PASET take 4 data bytes in order: start hi, start lo, end hi, end lo. Bytes are staged.
  - The window commits on the 4th byte only if start ≤ end < WIDTH (or HEIGHT for PASET); otherwise the window is unchanged.
  - FSM returns to IDLE after the 4th byte.
- RAMWR_HI stores the high byte. RAMWR_LO forms the pixel and pulses pixel_valid with the current px/py, then advances:
  - if x==xe: x←xs, and if y==ye then y←ys with frame_done, else y+1.
  - otherwise x+1.
  - Writing continues indefinitely, wrapping the window.
- Data bytes in IDLE are ignored (byte_valid still pulses).
- Reset values:
  - All pulses 0; byte_out, pixel, px, py = 0; sleep_out = display_on = 0.
  - Window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1; FSM in IDLE.
  - Reset mid-byte or mid-pixel discards all partial state.

## Timing

- clk must be ≥ 4× scl frequency. scl high and low phases must each be ≥ 2 clk periods.
- byte_valid asserts SYNC_STAGES+1 cycles after the 8th scl rising edge at the pins.
- pixel_valid, px/py and frame_done are registered and assert 1 cycle after the byte_valid of the low byte.
- Command decode and window commit take effect in the cycle after byte_valid.
- cs rising and an scl edge in the same synchronized cycle: cs wins and the byte is discarded.

## Structure

- Package lcd_pkg holds:
  - command constants CMD_SLPOUT=8'h11, CMD_DISPOFF=8'h28, CMD_DISPON=8'h29, CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C;
  - the decoder state enum;
  - the RGB565 pixel typedef.
- Sub-module lcd_spi_deser contains the synchronizers, scl edge detect, shift register and bit counter. It outputs byte_valid, byte_out and byte_is_data.

## Test plan

- Send command 0x11, then 0x29 -> sleep_out=1, display_on=1; two byte_valid pulses with byte_is_data=0.
- Send 0x2C followed by 2×WIDTH×HEIGHT data bytes -> 76800 pixel_valid pulses, px/py scanning 0..319/0..239; a single frame_done on pixel (319,239).
- Send 0x2A 00 0A 00 0B, 0x2B 00 05 00 06, 0x2C, then pixels -> coordinates (10,5),(11,5),(10,6),(11,6), frame_done, then wrap to (10,5).
- Send 0x2A 01 40 00 00 (start > end) -> window unchanged; next 0x2C starts at (0,0).
- Raise cs after 5 bits, then send a full 0x2C -> no byte from the partial frame; byte_out=0x2C.
- Assert reset between the high and low pixel bytes -> no pixel_valid; all outputs return to reset values.
